mux_from_pc_rs1_to_pc: RTL and testbench
========================================

Name: mux_from_pc_rs1_to_pc

Overview:
Jump-base selector for the single-cycle RV32 core.
- Chooses PC (JAL/branch) or rs1 (JALR) as the base of the next-PC target.
- Adds the immediate, clears bit 0 on the rs1 path and flags misalignment.
- Holds a registered copy of the last taken target for trace/debug.
- Sits between the register file/PC register and the next-PC mux.

Parameters:
XLEN, 32, datapath width in bits.
RESET_TARGET, 32'h0000_0000, reset value of the registered target.

Ports:
clk  input  1  core clock; registered state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
mrs1andpc_ctr2  input  1  base select: 0 = pc, 1 = rs1.
pc  input  XLEN  current program counter.
rs1  input  XLEN  register-file rs1 read data.
imm  input  XLEN  sign-extended jump/branch immediate.
jump_en  input  1  current instruction redirects the PC (capture strobe).
mrs1andpc_out  output  XLEN  selected base (combinational).
target  output  XLEN  computed jump target (combinational).
target_misaligned  output  1  target[1] set (combinational).
target_q  output  XLEN  last captured target (registered).
target_valid_q  output  1  target_q holds a captured value (registered).

Behaviour:
Combinational path (zero latency):
- mrs1andpc_out = mrs1andpc_ctr2 ? rs1 : pc. Must be purely combinational and independent of clk and rst_n.
- sum = mrs1andpc_out + imm, modulo 2^XLEN. No overflow flag.
- target = sum when ctr2 = 0; sum with bit 0 forced to 0 when ctr2 = 1 (JALR rule).
- target_misaligned = target[1]. IALIGN = 32, no compressed instructions.
- Any X on mrs1andpc_ctr2 propagates X to the combinational outputs; no masking.

Registered path:
- rst_n low (asynchronous, any time): target_q = RESET_TARGET, target_valid_q = 0, held while rst_n is low.
- Rising edge with rst_n high and jump_en = 1: target_q <= target; target_valid_q <= 1.
- Rising edge with jump_en = 0: both registers hold.
- Reset asserted at the same time as jump_en: reset wins.
- A capture is taken regardless of target_misaligned; the trap decision belongs to the control unit.

Decomposition:
- Shared package holds XLEN and the select encodings SEL_PC = 1'b0, SEL_RS1 = 1'b1.
- Optional sub-module: a generic 2:1 mux (mux2) instantiated for the base select.
- The adder and capture register stay inline.

Test Plan:
1. pc = 1, rs1 = 2, ctr2 = 0 -> mrs1andpc_out = 1; after 10 ns set ctr2 = 1 -> mrs1andpc_out = 2 with no clock edge needed.
2. ctr2 = 0, pc = 0x100, imm = 0xFFFF_FFF8 (-8) -> target = 0x0F8, target_misaligned = 0.
3. ctr2 = 1, rs1 = 0x203, imm = 0x4 -> sum 0x207, target = 0x206, target_misaligned = 1.
4. rs1 = 0xFFFF_FFFC, imm = 0x8, ctr2 = 1 -> target wraps to 0x0000_0004.
5. rst_n = 0 -> target_q = 0, valid = 0. Release, hold jump_en = 1 with target = 0x0F8 for one edge -> target_q = 0x0F8, valid = 1. Then jump_en = 0 with a new target -> target_q stays 0x0F8.
6. Assert rst_n low mid-cycle between edges with jump_en = 1 -> target_q and valid clear immediately, without waiting for an edge.

Source files
------------

// File: rtl/mux_from_pc_rs1_to_pc_pkg.sv
// Shared definitions for the jump-base selector: datapath width and the
// base-select encodings driven by the decoder onto mrs1andpc_ctr2.
package mux_from_pc_rs1_to_pc_pkg;

    // Default RV32 datapath width.
    localparam int XLEN = 32;

    // Base-select encodings.
    // SEL_PC  : JAL and conditional branches compute pc + imm.
    // SEL_RS1 : JALR computes (rs1 + imm) with bit 0 cleared.
    localparam logic SEL_PC  = 1'b0;
    localparam logic SEL_RS1 = 1'b1;

endpackage : mux_from_pc_rs1_to_pc_pkg

// File: rtl/mux_from_pc_rs1_to_pc_mux2.sv
// Generic 2:1 multiplexer. A select of 0 picks in0 and 1 picks in1.
// An unknown select is not masked, so X reaches the output.
module mux_from_pc_rs1_to_pc_mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    // Pure combinational select with no clock or reset involvement.
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule : mux_from_pc_rs1_to_pc_mux2

// File: rtl/mux_from_pc_rs1_to_pc.sv
// Jump-base selector for the single-cycle RV32 core.
//
// This block picks either pc (JAL/branch) or rs1 (JALR) as the base, then
// adds the immediate. On the rs1 path it clears bit 0 of the result. It
// flags targets that are not 4-byte aligned. It also keeps a registered
// copy of the last taken target for trace/debug.
//
// jump_en is a single-cycle capture strobe, not a handshake. On any rising
// edge where it is high, the current combinational target is captured.
// There is no backpressure.
module mux_from_pc_rs1_to_pc #(
    parameter int                                    XLEN         = mux_from_pc_rs1_to_pc_pkg::XLEN,
    parameter logic [XLEN-1:0]                       RESET_TARGET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mrs1andpc_ctr2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            jump_en,
    output logic [XLEN-1:0] mrs1andpc_out,
    output logic [XLEN-1:0] target,
    output logic            target_misaligned,
    output logic [XLEN-1:0] target_q,
    output logic            target_valid_q
);

    import mux_from_pc_rs1_to_pc_pkg::*;

    logic [XLEN-1:0] sum;

    // Base select between the PC register and the register-file read port.
    mux_from_pc_rs1_to_pc_mux2 #(
        .W (XLEN)
    ) u_base_mux (
        .sel (mrs1andpc_ctr2),
        .in0 (pc),
        .in1 (rs1),
        .out (mrs1andpc_out)
    );

    // Target arithmetic. The sum wraps modulo 2^XLEN on purpose, and no
    // overflow is reported. JALR drops bit 0 of the sum. The misalignment
    // flag only looks at bit 1, because compressed instructions are not
    // supported (IALIGN = 32).
    always_comb begin
        sum = mrs1andpc_out + imm;
        if (mrs1andpc_ctr2 == SEL_RS1) begin
            target = {sum[XLEN-1:1], 1'b0};
        end else begin
            target = sum;
        end
        target_misaligned = target[1];
    end

    // Trace capture of the last taken target. Reset takes priority over
    // jump_en. Misaligned targets are still captured, because the control
    // unit owns the trap decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q       <= RESET_TARGET;
            target_valid_q <= 1'b0;
        end else if (jump_en) begin
            target_q       <= target;
            target_valid_q <= 1'b1;
        end
    end

endmodule : mux_from_pc_rs1_to_pc

// File: tb/tb_mux_from_pc_rs1_to_pc.sv
// Directed bench for the jump-base selector. It has a table of
// combinational vectors plus hand-written sequences for capture and
// asynchronous reset.
`timescale 1ns/1ps
module tb_mux_from_pc_rs1_to_pc;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic         ctr2;
    logic [W-1:0] pc;
    logic [W-1:0] rs1;
    logic [W-1:0] imm;
    logic         jump_en;
    logic [W-1:0] base_out;
    logic [W-1:0] target;
    logic         target_mis;
    logic [W-1:0] target_q;
    logic         target_valid_q;

    mux_from_pc_rs1_to_pc #(
        .XLEN         (W),
        .RESET_TARGET (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mrs1andpc_ctr2    (ctr2),
        .pc                (pc),
        .rs1               (rs1),
        .imm               (imm),
        .jump_en           (jump_en),
        .mrs1andpc_out     (base_out),
        .target            (target),
        .target_misaligned (target_mis),
        .target_q          (target_q),
        .target_valid_q    (target_valid_q)
    );

    // ---------------- scoreboard ----------------
    int checks_total;
    int checks_passed;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic c, input logic [W-1:0] p, input logic [W-1:0] r,
                         input logic [W-1:0] i);
        ctr2 = c;
        pc   = p;
        rs1  = r;
        imm  = i;
    endtask

    // Pulse jump_en across one rising edge. The expected capture value is
    // pushed onto the scoreboard queue.
    task automatic capture(input logic [W-1:0] exp_target);
        @(negedge clk);
        jump_en = 1'b1;
        exp_q.push_back(exp_target);
        @(posedge clk);
        #1;
        jump_en = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        logic         ctr2;
        logic [W-1:0] pc;
        logic [W-1:0] rs1;
        logic [W-1:0] imm;
        logic [W-1:0] exp_base;
        logic [W-1:0] exp_target;
        logic         exp_mis;
    } vec_t;

    vec_t vecs[8];

    // Watchdog: a hang is reported as a failure and the run stops.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [W-1:0] exp_v;
        checks_total  = 0;
        checks_passed = 0;

        vecs[0] = '{"pc_sel",      1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[1] = '{"rs1_sel",     1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0002, 32'h0000_0002, 1'b1};
        vecs[2] = '{"neg_imm",     1'b0, 32'h0000_0100, 32'h0000_0055, 32'hFFFF_FFF8, 32'h0000_0100, 32'h0000_00F8, 1'b0};
        vecs[3] = '{"jalr_clr",    1'b1, 32'h0000_0100, 32'h0000_0203, 32'h0000_0004, 32'h0000_0203, 32'h0000_0206, 1'b1};
        vecs[4] = '{"rs1_wrap",    1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0};
        vecs[5] = '{"pc_wrap_odd", 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[6] = '{"jalr_odd",    1'b1, 32'h0000_0000, 32'h0000_1001, 32'h0000_0000, 32'h0000_1001, 32'h0000_1000, 1'b0};
        vecs[7] = '{"pc_mis",      1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0002, 32'h0000_1000, 32'h0000_1002, 1'b1};

        // Reset state.
        rst_n   = 1'b0;
        jump_en = 1'b0;
        drive(1'b0, '0, '0, '0);
        #12;
        check("reset_target_q", target_q, 32'h0);
        check("reset_valid", {31'b0, target_valid_q}, 32'h0);

        // Base select switches with no clock edge: change ctr2 mid-cycle.
        drive(1'b0, 32'h1, 32'h2, 32'h0);
        #1;
        check("sel_pc_comb", base_out, 32'h1);
        #10;
        ctr2 = 1'b1;
        #1;
        check("sel_rs1_comb", base_out, 32'h2);

        // Table of combinational vectors.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ctr2, vecs[i].pc, vecs[i].rs1, vecs[i].imm);
            #2;
            check({vecs[i].name, "_base"},   base_out, vecs[i].exp_base);
            check({vecs[i].name, "_target"}, target,   vecs[i].exp_target);
            check({vecs[i].name, "_mis"},    {31'b0, target_mis}, {31'b0, vecs[i].exp_mis});
        end

        // Release reset away from an edge, then capture pc - 8.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h100, 32'h0, 32'hFFFF_FFF8);
        capture(32'h0000_00F8);
        exp_v = exp_q.pop_front();
        check("cap1_target_q", target_q, exp_v);
        check("cap1_valid", {31'b0, target_valid_q}, 32'h1);

        // New target without jump_en: the register must hold.
        drive(1'b0, 32'h200, 32'h0, 32'h10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("hold_target_q", target_q, 32'h0000_00F8);
        check("hold_valid", {31'b0, target_valid_q}, 32'h1);

        // A misaligned JALR target is still captured.
        drive(1'b1, 32'h0, 32'h203, 32'h4);
        capture(32'h0000_0206);
        exp_v = exp_q.pop_front();
        check("cap_mis_target_q", target_q, exp_v);

        // Asynchronous reset mid-cycle with jump_en high clears at once.
        @(negedge clk);
        jump_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_target_q", target_q, 32'h0);
        check("async_rst_valid", {31'b0, target_valid_q}, 32'h0);

        // Reset wins over jump_en on a rising edge.
        @(posedge clk);
        #1;
        check("rst_wins_target_q", target_q, 32'h0);
        check("rst_wins_valid", {31'b0, target_valid_q}, 32'h0);

        // Release with jump_en low: still empty after an edge.
        @(negedge clk);
        jump_en = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'b0, target_valid_q}, 32'h0);

        // Capture after reset: wrapping rs1 path.
        drive(1'b1, 32'h0, 32'hFFFF_FFFC, 32'h8);
        capture(32'h0000_0004);
        exp_v = exp_q.pop_front();
        check("cap_wrap_target_q", target_q, exp_v);
        check("cap_wrap_valid", {31'b0, target_valid_q}, 32'h1);

        check("exp_q_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_mux_from_pc_rs1_to_pc
